spi_req_arbiter: RTL and testbench
==================================

# spi_req_arbiter

Round-robin arbiter and transaction sequencer that shares a single SPI mode-0 byte engine among N_REQ requesters. It grants one requester at a time, drives that requester's active-low chip select, hands the latched byte to the engine with a start pulse, and waits for the engine's done pulse. It then acknowledges the requester and enforces an inter-transaction gap. A watchdog aborts any transfer whose done pulse never arrives.

## Interface
Parameters:
- N_REQ, 4: number of requesters; legal range 2..8.
- CS_SETUP, 2: cycles from chip-select fall to spi_start; must be ≥1.
- GAP_CYCLES, 2: idle cycles with all chip selects high between transactions; must be ≥1.
- TIMEOUT, 64: cycles in WAIT with no spi_done before abort; must be ≥2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level; held high until ack or err.
- req_data  in  8*N_REQ  byte for requester i at bits [8i+7:8i]; held stable while req[i] is high.
- ack  out  N_REQ  one-cycle pulse on ack[g] when requester g's byte completes.
- err  out  1  one-cycle pulse on watchdog abort.
- err_id  out  clog2(N_REQ)  id of the aborted requester; valid while err is high, otherwise holds its last value.
- busy  out  1  high in every state except IDLE.
- spi_cs_n  out  N_REQ  per-slave chip select, active low; at most one bit low at any time.
- spi_start  out  1  one-cycle pulse telling the engine to shift spi_data.
- spi_data  out  8  latched byte; stable from grant until return to IDLE.
- spi_done  in  1  one-cycle pulse from the engine when the 8th bit has shifted.

## Operation
- States: IDLE, SETUP, WAIT, GAP. Encoding is free.
- Reset values: state IDLE, rr_ptr 0, spi_cs_n all 1, spi_start 0, spi_data 0, ack 0, err 0, err_id 0, busy 0, counters 0.
- **IDLE.** When req is nonzero at a clock edge:
  - grant g = first set bit of req, searching upward from rr_ptr and wrapping modulo N_REQ.
  - Latch req_data[g] into spi_data, drive spi_cs_n[g] low, clear cnt, go to SETUP.
  - When req is zero, stay in IDLE.
- **SETUP.** cnt increments each edge. On the edge where cnt == CS_SETUP-1, assert spi_start for exactly one cycle, clear the timeout counter, go to WAIT.
- **WAIT.**
  - spi_done high: drive spi_cs_n[g] high, pulse ack[g], set rr_ptr = (g+1) mod N_REQ, go to GAP.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with no spi_done: drive spi_cs_n[g] high, pulse err, set err_id = g, send no ack, advance rr_ptr as on completion, go to GAP.
- **GAP.** Count GAP_CYCLES cycles with all spi_cs_n high, then go to IDLE. New requests are not sampled before IDLE.
- spi_done outside WAIT is ignored.
- spi_done in the same cycle the timeout would fire: done wins; ack is issued, not err.
- Dropping req[g] mid-transaction does not abort. The transfer completes and ack[g] still pulses.
- req bits for non-granted requesters may change freely. Only the value at the IDLE sampling edge matters.
- Asynchronous reset in any state returns all outputs to their reset values immediately. Any open chip select goes high at once, with no ack and no err.
- Counter widths: cnt uses clog2(max(CS_SETUP,GAP_CYCLES)+1) bits; the timeout counter uses clog2(TIMEOUT+1) bits. rr_ptr wraps from N_REQ-1 to 0.

## Timing
- Let E0 be the edge at which IDLE samples req.
- spi_cs_n[g] is low from E0 onward.
- spi_start is high during the single cycle following edge E0+CS_SETUP.
- Completion: if spi_done is high in cycle C, ack[g] is high and spi_cs_n[g] is high in cycle C+1.
- Abort: err is high TIMEOUT cycles after the spi_start cycle.
- IDLE is reached GAP_CYCLES cycles after the ack or err cycle.
- Minimum request-to-request spacing with an instant done is CS_SETUP + 1 + 1 + GAP_CYCLES + 1 cycles.
- The ack, err and spi_start pulses are never wider than one cycle.
- busy rises the cycle after E0 and falls on entry to IDLE.

## Test plan
- **Single request, defaults.** req=4'b0010, req_data[15:8]=8'hB1, spi_done 3 cycles after spi_start:
  - spi_cs_n=4'b1101 from E0.
  - spi_start 2 cycles after cs_n falls.
  - spi_data=8'hB1.
  - ack=4'b0010 one cycle after done.
  - cs_n=4'hF.
  - busy low 2 cycles later.
- **Round-robin fairness.** req=4'b1111 held, each requester dropped after its ack, done after 1 cycle: grants in order 0,1,2,3. Then re-raise req[0] and req[2]: order 0,2.
- **Wrap-around.** rr_ptr=3 (after a grant to 2), req=4'b1001: grant 3, then grant 0.
- **Timeout.** req=4'b0100, spi_done never asserted: err pulse with err_id=2 exactly 64 cycles after spi_start, no ack, cs_n=4'hF, next grant starts from requester 3.
- **Done/timeout collision.** spi_done asserted on the cycle the counter hits TIMEOUT-1: ack[g] pulses and err stays 0. Also, spi_done pulsed in IDLE or GAP has no effect.
- **Reset mid-WAIT.** rst_n low asynchronously between edges: spi_cs_n=4'hF, busy=0 and spi_start=0 before the next edge. After release, with req held, the arbiter regrants from requester 0.

Source files
------------

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter and transaction sequencer that shares one SPI byte engine among
// N_REQ requesters. One requester is granted at a time. The sequencer drives that
// requester's chip select, starts the engine, and waits for done or a watchdog abort.
// It then holds all chip selects high for an inter-transaction gap.
module spi_req_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       err,
    output logic [$clog2(N_REQ)-1:0]   err_id,
    output logic                       busy,
    output logic [N_REQ-1:0]           spi_cs_n,
    output logic                       spi_start,
    output logic [7:0]                 spi_data,
    input  logic                       spi_done
);

    localparam int unsigned IdW    = $clog2(N_REQ);
    localparam int unsigned CntMax = (CS_SETUP > GAP_CYCLES) ? CS_SETUP : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT - 1);
    localparam logic [IdW-1:0]  LastId    = IdW'(N_REQ - 1);
    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam logic [IdW:0]    NReqW     = (IdW + 1)'(N_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWait,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]   gnt_q, gnt_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [N_REQ-1:0] cs_n_q, cs_n_d;
    logic             start_q, start_d;
    logic [7:0]       data_q, data_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;
    logic [IdW-1:0]   err_id_q, err_id_d;

    logic             pick_found;
    logic [IdW-1:0]   pick_id;
    logic [IdW:0]     rr_sum;
    logic [7:0]       pick_data;
    logic [IdW-1:0]   next_ptr;

    // Round-robin pick: first set request bit at or above rr_ptr, wrapping to zero.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr_q;
        rr_sum     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (IdW + 1)'(i);
            if (rr_sum >= NReqW) begin
                rr_sum = rr_sum - NReqW;
            end
            if (!pick_found && req[rr_sum[IdW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = rr_sum[IdW-1:0];
            end
        end
    end

    // Byte of the winning requester and the pointer value after the current grant.
    always_comb begin
        pick_data = req_data[{pick_id, 3'b000} +: 8];
        next_ptr  = (gnt_q == LastId) ? '0 : gnt_q + IdW'(1);
    end

    // Sequencer next-state logic; pulse outputs default low every cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        cs_n_d   = cs_n_q;
        start_d  = 1'b0;
        data_d   = data_q;
        ack_d    = '0;
        err_d    = 1'b0;
        err_id_d = err_id_q;

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d   = pick_id;
                    data_d  = pick_data;
                    cs_n_d  = ~(N_REQ'(1) << pick_id);
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == SetupLast) begin
                    start_d = 1'b1;
                    tmo_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StWait: begin
                // Done is checked first so it wins a tie with the watchdog.
                if (spi_done) begin
                    cs_n_d   = '1;
                    ack_d    = N_REQ'(1) << gnt_q;
                    rr_ptr_d = next_ptr;
                    cnt_d    = '0;
                    state_d  = StGap;
                end else if (tmo_q == TmoLast) begin
                    cs_n_d   = '1;
                    err_d    = 1'b1;
                    err_id_d = gnt_q;
                    rr_ptr_d = next_ptr;
                    cnt_d    = '0;
                    state_d  = StGap;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end

            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                cs_n_d  = '1;
            end
        endcase
    end

    // State and registered outputs; reset closes any open chip select at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            cs_n_q   <= '1;
            start_q  <= 1'b0;
            data_q   <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            cs_n_q   <= cs_n_d;
            start_q  <= start_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    // Output wiring; busy follows the state register so reset clears it immediately.
    always_comb begin
        ack       = ack_q;
        err       = err_q;
        err_id    = err_id_q;
        busy      = (state_q != StIdle);
        spi_cs_n  = cs_n_q;
        spi_start = start_q;
        spi_data  = data_q;
    end

`ifndef SYNTHESIS
    // At most one slave may be selected.
    a_cs_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(~spi_cs_n) <= 1);
    // Pulse outputs never stretch past one cycle.
    a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        spi_start |=> !spi_start);
    a_err_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        err |=> !err);
    a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        (|ack) |=> !(|ack));
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: a table of transactions with expected grant order,
// plus hand-written sequences for watchdog abort, stray done pulses and mid-WAIT reset.
module tb_spi_req_arbiter;

    localparam int unsigned N_REQ      = 4;
    localparam int unsigned CS_SETUP   = 2;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 64;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [31:0]      req_data;
    logic [3:0]       ack;
    logic             err;
    logic [1:0]       err_id;
    logic             busy;
    logic [3:0]       spi_cs_n;
    logic             spi_start;
    logic [7:0]       spi_data;
    logic             spi_done;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [7:0] data_tab [4];

    typedef struct {
        logic [3:0]  set;       // request bits raised before the transaction
        int unsigned gnt;       // expected granted requester
        int unsigned dly;       // cycles from spi_start to spi_done
        bit          gap_done;  // pulse a stray spi_done during GAP
    } row_t;

    row_t rows [11];

    spi_req_arbiter #(
        .N_REQ      (N_REQ),
        .CS_SETUP   (CS_SETUP),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .err       (err),
        .err_id    (err_id),
        .busy      (busy),
        .spi_cs_n  (spi_cs_n),
        .spi_start (spi_start),
        .spi_data  (spi_data),
        .spi_done  (spi_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for any chip select to fall; returns at E0 + 1 sample point.
    task automatic wait_cs(output bit hit);
        int unsigned n;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (spi_cs_n != 4'hF) hit = 1'b1;
        end
        chk("grant_seen", 32'(hit), 32'd1);
    endtask

    // Count cycles until spi_start is seen; returns inside the start cycle.
    task automatic wait_start(output int unsigned k, output bit hit);
        hit = 1'b0;
        k   = 0;
        while (!hit && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (spi_start) hit = 1'b1;
        end
    endtask

    task automatic run_txn(input logic [3:0] set, input int unsigned g,
                           input int unsigned dly, input bit gap_done);
        bit          hit;
        int unsigned k;
        bit          saw_err;
        bit          saw_ack;
        logic [3:0]  exp_cs;
        logic [3:0]  exp_ack;
        exp_cs  = ~(4'b0001 << g);
        exp_ack = 4'b0001 << g;
        req     = req | set;
        wait_cs(hit);
        if (!hit) return;
        chk("cs_n_grant", 32'(spi_cs_n), 32'(exp_cs));
        chk("spi_data", 32'(spi_data), 32'(data_tab[g]));
        chk("busy_set", 32'(busy), 32'd1);
        wait_start(k, hit);
        chk("start_latency", k, CS_SETUP);
        if (!hit) return;
        saw_err = 1'b0;
        saw_ack = 1'b0;
        for (int i = 1; i <= int'(dly); i++) begin
            @(posedge clk); #1;
            if (i == 1) chk("start_width", 32'(spi_start), 32'd0);
            if (err) saw_err = 1'b1;
            if (ack != 4'h0) saw_ack = 1'b1;
        end
        chk("no_err_in_wait", 32'(saw_err), 32'd0);
        chk("no_ack_in_wait", 32'(saw_ack), 32'd0);
        spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0;
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("cs_n_release", 32'(spi_cs_n), 32'hF);
        chk("err_on_ack", 32'(err), 32'd0);
        req[g] = 1'b0;
        @(posedge clk); #1;
        chk("ack_width", 32'(ack), 32'd0);
        chk("busy_gap", 32'(busy), 32'd1);
        if (gap_done) spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("ack_after_gap", 32'(ack), 32'd0);
        chk("cs_n_idle", 32'(spi_cs_n), 32'hF);
    endtask

    initial begin
        bit          hit;
        int unsigned k;
        bit          saw_ack;

        n_cmp       = 0;
        n_bad       = 0;
        data_tab[0] = 8'hA0;
        data_tab[1] = 8'hB1;
        data_tab[2] = 8'hC2;
        data_tab[3] = 8'hD3;
        req_data    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req         = 4'h0;
        spi_done    = 1'b0;
        rst_n       = 1'b0;

        // Fairness 0..3, re-raise 0 and 2, single request, wrap-around, done/timeout tie.
        rows[0]  = '{4'b1111, 0, 1, 1'b0};
        rows[1]  = '{4'b0000, 1, 1, 1'b0};
        rows[2]  = '{4'b0000, 2, 1, 1'b0};
        rows[3]  = '{4'b0000, 3, 1, 1'b0};
        rows[4]  = '{4'b0101, 0, 2, 1'b0};
        rows[5]  = '{4'b0000, 2, 2, 1'b0};
        rows[6]  = '{4'b0010, 1, 3, 1'b0};
        rows[7]  = '{4'b0100, 2, 1, 1'b0};
        rows[8]  = '{4'b1001, 3, 1, 1'b0};
        rows[9]  = '{4'b0000, 0, 1, 1'b0};
        rows[10] = '{4'b1000, 3, TIMEOUT - 1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(spi_cs_n), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(spi_start), 32'd0);
        chk("rst_data", 32'(spi_data), 32'd0);
        chk("rst_ack_err", 32'({ack, err, err_id}), 32'd0);
        rst_n = 1'b1;

        for (int r = 0; r < 11; r++) begin
            run_txn(rows[r].set, rows[r].gnt, rows[r].dly, rows[r].gap_done);
        end

        // Watchdog abort on requester 2.
        req = 4'b0100;
        wait_cs(hit);
        chk("tmo_cs_n", 32'(spi_cs_n), 32'hB);
        wait_start(k, hit);
        chk("tmo_start_latency", k, CS_SETUP);
        k       = 0;
        hit     = 1'b0;
        saw_ack = 1'b0;
        while (!hit && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (ack != 4'h0) saw_ack = 1'b1;
            if (err) hit = 1'b1;
        end
        chk("tmo_latency", k, TIMEOUT);
        chk("tmo_err_id", 32'(err_id), 32'd2);
        chk("tmo_cs_n_release", 32'(spi_cs_n), 32'hF);
        chk("tmo_no_ack", 32'(saw_ack), 32'd0);
        req = 4'h0;
        @(posedge clk); #1;
        chk("tmo_err_width", 32'(err), 32'd0);
        chk("tmo_err_id_hold", 32'(err_id), 32'd2);
        chk("tmo_busy_gap", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("tmo_busy_idle", 32'(busy), 32'd0);

        // Stray done while idle must do nothing.
        spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0;
        chk("idle_done_ack", 32'(ack), 32'd0);
        chk("idle_done_busy", 32'(busy), 32'd0);
        chk("idle_done_cs_n", 32'(spi_cs_n), 32'hF);

        // Pointer was advanced past 2 by the abort, so 3 beats 0.
        run_txn(4'b1001, 3, 2, 1'b0);
        run_txn(4'b0000, 0, 1, 1'b0);
        run_txn(4'b0010, 1, 1, 1'b0);

        // Reset during the spi_start cycle of a grant to requester 2.
        req = 4'b0110;
        wait_cs(hit);
        chk("rst_seq_cs_n", 32'(spi_cs_n), 32'hB);
        wait_start(k, hit);
        chk("rst_seq_start", 32'(hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(spi_cs_n), 32'hF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_start", 32'(spi_start), 32'd0);
        chk("mid_rst_data", 32'(spi_data), 32'd0);
        chk("mid_rst_ack_err", 32'({ack, err}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Pointer back to 0, so requester 1 wins over 2.
        run_txn(4'b0000, 1, 1, 1'b0);
        run_txn(4'b0000, 2, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
